// File: rtl/tc_mult_rescale_pipe_if.sv
// rtl/tc_mult_rescale_pipe_if.sv - operand/result handshake bundle for the TC rescale stage
interface tc_mult_rescale_pipe_if #(
    parameter int OUT_W = 14,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [15:0]             in_a;
    logic signed [16:0]      in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_sat;
    logic [CNT_W-1:0]        sat_count;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_sat, sat_count
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_sat, sat_count
    );
endinterface

// File: rtl/tc_mult_rescale_pipe.sv
// rtl/tc_mult_rescale_pipe.sv - 3-stage 16u x 17s multiply, shift and saturate; TC_RESCALE_ROUND_EN adds round-half-up
module tc_mult_rescale_pipe #(
    parameter int SHIFT = 14,
    parameter int OUT_W = 14,
    parameter int CNT_W = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    tc_mult_rescale_pipe_if.slave bus
);
    localparam int P_W = 31;
    localparam int R_W = P_W + 2;
    localparam logic signed [R_W-1:0] OUT_MAX = (R_W'(1) <<< (OUT_W - 1)) - R_W'(1);
    localparam logic signed [R_W-1:0] OUT_MIN = -(R_W'(1) <<< (OUT_W - 1));

    logic                    s1_v_q, s2_v_q, s3_v_q;
    logic [15:0]             s1_a_q;
    logic signed [16:0]      s1_b_q;
    logic signed [P_W-1:0]   s2_p_q, s2_p_d;
    logic signed [OUT_W-1:0] s3_data_q, s3_data_d;
    logic                    s3_sat_q, s3_sat_d;
    logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;

    logic                    ld1, ld2, ld3;
    logic signed [P_W-1:0]   a_ext, b_ext;
    logic signed [R_W-1:0]   p_ext, rnd_sum, r_shift;

    // Bubble-collapsing load chain: a stage loads when empty or when its successor moves.
    assign ld3 = !s3_v_q || bus.out_ready;
    assign ld2 = !s2_v_q || ld3;
    assign ld1 = !s1_v_q || ld2;

    assign bus.in_ready  = ld1 && !ap_rst;
    assign bus.out_valid = s3_v_q;
    assign bus.out_data  = s3_data_q;
    assign bus.out_sat   = s3_sat_q;
    assign bus.sat_count = sat_cnt_q;

    // Multiplying at P_W bits keeps exactly the low 31 bits of the full product.
    assign a_ext  = {{(P_W - 16){1'b0}}, s1_a_q};
    assign b_ext  = {{(P_W - 17){s1_b_q[16]}}, s1_b_q};
    assign s2_p_d = a_ext * b_ext;

    assign p_ext = {{(R_W - P_W){s2_p_q[P_W-1]}}, s2_p_q};
`ifdef TC_RESCALE_ROUND_EN
    assign rnd_sum = p_ext + (R_W'(1) <<< (SHIFT - 1));
`else
    assign rnd_sum = p_ext;
`endif
    assign r_shift = rnd_sum >>> SHIFT;

    always_comb begin
        s3_data_d = r_shift[OUT_W-1:0];
        s3_sat_d  = 1'b0;
        if (r_shift > OUT_MAX) begin
            s3_data_d = OUT_MAX[OUT_W-1:0];
            s3_sat_d  = 1'b1;
        end else if (r_shift < OUT_MIN) begin
            s3_data_d = OUT_MIN[OUT_W-1:0];
            s3_sat_d  = 1'b1;
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (s3_v_q && bus.out_ready && s3_sat_q && (sat_cnt_q != {CNT_W{1'b1}}))
            sat_cnt_d = sat_cnt_q + 1'b1;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s2_p_q    <= '0;
            s3_data_q <= '0;
            s3_sat_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (ld1) begin
                s1_v_q <= bus.in_valid;
                s1_a_q <= bus.in_a;
                s1_b_q <= bus.in_b;
            end
            if (ld2) begin
                s2_v_q <= s1_v_q;
                s2_p_q <= s2_p_d;
            end
            if (ld3) begin
                s3_v_q    <= s2_v_q;
                s3_data_q <= s3_data_d;
                s3_sat_q  <= s3_sat_d;
            end
            sat_cnt_q <= sat_cnt_d;
        end
    end
endmodule

// File: tb/tb_tc_mult_rescale_pipe.sv
// tb/tb_tc_mult_rescale_pipe.sv - scoreboard bench for tc_mult_rescale_pipe (vector table plus corner sequences)
module tb_tc_mult_rescale_pipe;
    localparam int OUT_W = 14;
    localparam int CNT_W = 16;
    localparam int NV    = 12;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    tc_mult_rescale_pipe_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    tc_mult_rescale_pipe #(.SHIFT(14), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.slave)
    );

    typedef struct {
        logic signed [13:0] d;
        logic               s;
    } exp_t;

    typedef struct {
        logic [15:0]        a;
        logic signed [16:0] b;
        logic signed [13:0] d;
        logic               s;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[NV];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_pop = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic signed [16:0] b);
        longint p, r;
        exp_t   e;
        p = longint'(a) * longint'(b);
        p = p & 64'h7FFF_FFFF;
        if (p >= 64'sh4000_0000) p = p - 64'sh8000_0000;
`ifdef TC_RESCALE_ROUND_EN
        p = p + 8192;
`endif
        r = p >>> 14;
        if (r > 8191) begin
            e.d = 14'sd8191;  e.s = 1'b1;
        end else if (r < -8192) begin
            e.d = -14'sd8192; e.s = 1'b1;
        end else begin
            e.d = 14'(r);     e.s = 1'b0;
        end
        return e;
    endfunction

    always @(negedge ap_clk) begin
        if (!ap_rst && bus.out_valid && bus.out_ready) begin
            n_pop++;
            if (sbq.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_data", bus.out_data, e.d);
                chk("out_sat", bus.out_sat, e.s);
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic signed [16:0] b, input exp_t e);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge ap_clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge ap_clk);
            t++;
        end
        if (!bus.in_ready) chk("send_timeout", 0, 1);
        else sbq.push_back(e);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        chk("drain_left", sbq.size(), 0);
    endtask

    task automatic pulse_reset();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        sbq.delete();
    endtask

    initial begin
        exp_t        e;
        int          sat_sum;
        int          idx;
        int          p0;
        bit          done;
        logic [15:0] ba[5];
        logic [16:0] bb[5];

`ifdef TC_RESCALE_ROUND_EN
        tbl[1]  = '{16'd1,     17'sd8192,   14'sd1,     1'b0};
        tbl[2]  = '{16'd1,     -17'sd8192,  14'sd0,     1'b0};
        tbl[11] = '{16'd16383, 17'sd8192,   14'sd8191,  1'b1};
`else
        tbl[1]  = '{16'd1,     17'sd8192,   14'sd0,     1'b0};
        tbl[2]  = '{16'd1,     -17'sd8192,  -14'sd1,    1'b0};
        tbl[11] = '{16'd16383, 17'sd8192,   14'sd8191,  1'b0};
`endif
        tbl[0]  = '{16'd16384, 17'sd100,    14'sd100,   1'b0};
        tbl[3]  = '{16'd32768, 17'sd32767,  14'sd8191,  1'b1};
        tbl[4]  = '{16'd32768, -17'sd32768, -14'sd8192, 1'b1};
        tbl[5]  = '{16'd0,     17'sd12345,  14'sd0,     1'b0};
        tbl[6]  = '{16'd65535, -17'sd65536, 14'sd4,     1'b0};
        tbl[7]  = '{16'd8191,  17'sd16384,  14'sd8191,  1'b0};
        tbl[8]  = '{16'd8192,  17'sd16384,  14'sd8191,  1'b1};
        tbl[9]  = '{16'd8192,  -17'sd16384, -14'sd8192, 1'b0};
        tbl[10] = '{16'd8193,  -17'sd16384, -14'sd8192, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        tick();
        @(negedge ap_clk);
        chk("rst_in_ready_low", bus.in_ready, 0);
        tick();
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_sat", bus.out_sat, 0);
        chk("rst_sat_count", bus.sat_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        tick();

        e.d = tbl[0].d; e.s = tbl[0].s;
        send(tbl[0].a, tbl[0].b, e);
        for (int n = 1; n <= 3; n++) begin
            @(negedge ap_clk);
            chk($sformatf("latency_valid_%0d", n), bus.out_valid, (n == 3) ? 1 : 0);
        end
        tick();
        drain();

        sat_sum = 0;
        for (int i = 1; i < NV; i++) begin
            e.d = tbl[i].d; e.s = tbl[i].s;
            send(tbl[i].a, tbl[i].b, e);
            sat_sum += tbl[i].s;
        end
        drain();
        chk("tbl_sat_count", bus.sat_count, sat_sum);

        pulse_reset();
        send(16'd32768, 17'sd32767, model(16'd32768, 17'sd32767));
        send(16'd32768, -17'sd32768, model(16'd32768, -17'sd32768));
        drain();
        chk("sat_pair_count", bus.sat_count, 2);

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    logic [15:0] ra;
                    logic [16:0] rb;
                    ra = 16'($urandom);
                    rb = 17'($urandom);
                    send(ra, rb, model(ra, rb));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    bus.out_ready = 1'($urandom);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 5; i++) begin
            ba[i] = 16'($urandom);
            bb[i] = 17'($urandom);
        end
        bus.out_ready = 1'b0;
        idx = 0;
        p0  = n_pop;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (idx >= 5 && sbq.size() == 0) break;
            bus.in_valid = (idx < 5);
            if (idx < 5) begin
                bus.in_a = ba[idx];
                bus.in_b = bb[idx];
            end
            if (cyc == 6) begin
                bus.out_ready = 1'b1;
                p0 = n_pop;
            end
            @(negedge ap_clk);
            if (cyc == 2) chk("bp_third_accept", bus.in_ready, 1);
            if (cyc == 3 || cyc == 5) chk($sformatf("bp_full_c%0d", cyc), bus.in_ready, 0);
            if (bus.in_valid && bus.in_ready) begin
                sbq.push_back(model(ba[idx], bb[idx]));
                idx++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", idx, 5);
        chk("bp_burst_len", n_pop - p0, 5);
        drain();

        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'd32768, 17'sd32767, model(16'd32768, 17'sd32767));
        ap_rst = 1'b1;
        @(negedge ap_clk);
        chk("midrst_in_ready_low", bus.in_ready, 0);
        tick();
        ap_rst = 1'b0;
        sbq.delete();
        @(negedge ap_clk);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sat_count", bus.sat_count, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        tick();
        bus.out_ready = 1'b1;
        p0 = n_pop;
        repeat (8) tick();
        chk("midrst_no_stale", n_pop - p0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
